// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared types and width helpers for the vec_mul feeder path
package vec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_K = 2'd1,
    RUN    = 2'd2,
    DRAIN  = 2'd3
  } feeder_state_t;

  typedef struct packed {
    logic v;
    logic last;
  } tag_t;

  function automatic int depth_f(input int c);
    return (c > 1) ? $clog2(c) : 0;
  endfunction

  function automatic int wy_f(input int c, input int w_x, input int w_k);
    return w_x + w_k + depth_f(c);
  endfunction

endpackage

// File: rtl/vec_tag_pipe.sv
// rtl/vec_tag_pipe.sv - N-stage always-shifting tag pipeline that mirrors the PE latency
module vec_tag_pipe
  import vec_pkg::*;
#(
  parameter int N = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t [N-1:0] stage_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < N; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[N-1];

endmodule

// File: rtl/vec_feeder.sv
// rtl/vec_feeder.sv - packs serial kernel/activation streams into PE vectors and tags results
module vec_feeder
  import vec_pkg::*;
#(
  parameter int C   = 8,
  parameter int W_X = 8,
  parameter int W_K = 8,
  localparam int DEPTH = depth_f(C),
  localparam int W_Y   = wy_f(C, W_X, W_K)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          reload_k,
  input  logic                          k_in_valid,
  output logic                          k_in_ready,
  input  logic [W_K-1:0]                k_in_data,
  input  logic                          x_in_valid,
  output logic                          x_in_ready,
  input  logic [W_X-1:0]                x_in_data,
  input  logic                          x_in_last,
  output logic                          enable,
  output logic [C-1:0][W_K-1:0]         k,
  output logic [C-1:0][W_X-1:0]         x,
  input  logic signed [W_Y-1:0]         y,
  output logic                          r_valid,
  output logic signed [W_Y-1:0]         r_data,
  output logic                          r_last,
  output logic                          busy
);

  localparam int CW = (DEPTH > 0) ? DEPTH : 1;
  localparam logic [CW-1:0] LAST_LANE  = CW'(C - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DEPTH);

  feeder_state_t state_q, state_d;
  logic [CW-1:0] kcnt_q, kcnt_d;
  logic [CW-1:0] xcnt_q, xcnt_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic [C-1:0][W_K-1:0] k_q, k_d;
  logic [C-1:0][W_X-1:0] x_q, x_d;
  logic issue_q, issue_d;
  logic issue_last_q, issue_last_d;
  tag_t tag_in, tag_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      kcnt_q       <= '0;
      xcnt_q       <= '0;
      dcnt_q       <= '0;
      k_q          <= '0;
      x_q          <= '0;
      issue_q      <= 1'b0;
      issue_last_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      kcnt_q       <= kcnt_d;
      xcnt_q       <= xcnt_d;
      dcnt_q       <= dcnt_d;
      k_q          <= k_d;
      x_q          <= x_d;
      issue_q      <= issue_d;
      issue_last_q <= issue_last_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    kcnt_d       = kcnt_q;
    xcnt_d       = xcnt_q;
    dcnt_d       = dcnt_q;
    k_d          = k_q;
    x_d          = x_q;
    issue_d      = 1'b0;
    issue_last_d = 1'b0;
    k_in_ready   = 1'b0;
    x_in_ready   = 1'b0;
    enable       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = reload_k ? LOAD_K : RUN;
        end
      end

      LOAD_K: begin
        k_in_ready = 1'b1;
        if (k_in_valid) begin
          k_d[kcnt_q] = k_in_data;
          if (kcnt_q == LAST_LANE) begin
            kcnt_d  = '0;
            state_d = RUN;
          end else begin
            kcnt_d = kcnt_q + 1'b1;
          end
        end
      end

      RUN: begin
        x_in_ready = 1'b1;
        enable     = 1'b1;
        if (x_in_valid) begin
          x_d[xcnt_q] = x_in_data;
          if (x_in_last) begin
            // Lanes beyond the final element are zeroed so a short vector adds nothing stale.
            for (int i = 0; i < C; i++) begin
              if (i > int'(xcnt_q)) begin
                x_d[i] = '0;
              end
            end
            issue_d      = 1'b1;
            issue_last_d = 1'b1;
            xcnt_d       = '0;
            dcnt_d       = '0;
            state_d      = DRAIN;
          end else if (xcnt_q == LAST_LANE) begin
            issue_d = 1'b1;
            xcnt_d  = '0;
          end else begin
            xcnt_d = xcnt_q + 1'b1;
          end
        end
      end

      DRAIN: begin
        // Keep the PE clocked until the final vector reaches its output register.
        enable = 1'b1;
        if (dcnt_q == DRAIN_LAST) begin
          dcnt_d  = '0;
          state_d = IDLE;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tag_in = '{v: issue_q, last: issue_last_q};

  vec_tag_pipe #(
    .N(DEPTH + 1)
  ) u_tag_pipe (
    .clk_i (clk),
    .rst_ni(rst_n),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  assign k       = k_q;
  assign x       = x_q;
  assign r_valid = tag_out.v;
  assign r_last  = tag_out.last;
  assign r_data  = y;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_vec_feeder.sv
// tb/tb_vec_feeder.sv - directed job table plus reset-abort sequence for vec_feeder
module tb_vec_feeder;

  localparam int C     = 8;
  localparam int W_X   = 8;
  localparam int W_K   = 8;
  localparam int DEPTH = 3;
  localparam int W_Y   = W_X + W_K + DEPTH;
  localparam int LAT   = DEPTH + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic reload_k = 1'b0;
  logic k_in_valid = 1'b0;
  logic k_in_ready;
  logic [W_K-1:0] k_in_data = '0;
  logic x_in_valid = 1'b0;
  logic x_in_ready;
  logic [W_X-1:0] x_in_data = '0;
  logic x_in_last = 1'b0;
  logic enable;
  logic [C-1:0][W_K-1:0] k;
  logic [C-1:0][W_X-1:0] x;
  logic signed [W_Y-1:0] y;
  logic r_valid;
  logic signed [W_Y-1:0] r_data;
  logic r_last;
  logic busy;

  vec_feeder #(.C(C), .W_X(W_X), .W_K(W_K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .reload_k  (reload_k),
    .k_in_valid(k_in_valid),
    .k_in_ready(k_in_ready),
    .k_in_data (k_in_data),
    .x_in_valid(x_in_valid),
    .x_in_ready(x_in_ready),
    .x_in_data (x_in_data),
    .x_in_last (x_in_last),
    .enable    (enable),
    .k         (k),
    .x         (x),
    .y         (y),
    .r_valid   (r_valid),
    .r_data    (r_data),
    .r_last    (r_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Behavioural PE: input register plus DEPTH tree levels, frozen while enable is low.
  int pe [DEPTH+1] = '{default: 0};

  function automatic int dot(input logic [C-1:0][W_K-1:0] kk, input logic [C-1:0][W_X-1:0] xx);
    int s = 0;
    for (int i = 0; i < C; i++) s += int'($signed(kk[i])) * int'($signed(xx[i]));
    return s;
  endfunction

  always @(posedge clk) begin
    if (enable) begin
      pe[0] <= dot(k, x);
      for (int i = 1; i <= DEPTH; i++) pe[i] <= pe[i-1];
    end
  end
  assign y = W_Y'(pe[DEPTH]);

  typedef struct {
    int   data;
    logic last;
    int   cyc;
  } res_t;

  res_t res_q[$];
  int   cyc = 0;
  int   k_ready_cnt = 0;
  int   last_xfer_cyc = 0;
  int   busy_fall_cyc = 0;
  logic busy_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    busy_prev <= busy;
    if (r_valid) res_q.push_back('{int'(r_data), r_last, cyc});
    if (k_in_ready) k_ready_cnt <= k_ready_cnt + 1;
    if (x_in_valid && x_in_ready && x_in_last) last_xfer_cyc <= cyc;
    if (busy_prev && !busy) busy_fall_cyc <= cyc;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out, got no handshake, required one", nm);
  endtask

  task automatic send_k(input logic [W_K-1:0] d);
    int t = 0;
    k_in_valid = 1'b1;
    k_in_data  = d;
    @(negedge clk);
    while (!k_in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!k_in_ready) timeout("k_handshake");
    @(posedge clk); #1;
    k_in_valid = 1'b0;
  endtask

  task automatic send_x(input logic [W_X-1:0] d, input logic last, input logic gaps);
    int t = 0;
    if (gaps && $urandom_range(1) == 1) begin
      x_in_valid = 1'b0;
      @(posedge clk); #1;
    end
    x_in_valid = 1'b1;
    x_in_data  = d;
    x_in_last  = last;
    @(negedge clk);
    while (!x_in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!x_in_ready) timeout("x_handshake");
    @(posedge clk); #1;
    x_in_valid = 1'b0;
    x_in_last  = 1'b0;
  endtask

  typedef struct {
    logic        reload;
    logic        gaps;
    logic [63:0] kv;
    int          nx;
    int          xval;
    int          xinc;
    int          exp_n;
    int          exp_y;
    int          exp_inc;
  } job_t;

  job_t jobs[8];

  task automatic run_job(input int j);
    job_t jb;
    int base, kbase, n, t;
    jb    = jobs[j];
    base  = res_q.size();
    kbase = k_ready_cnt;
    reload_k = jb.reload;
    start    = 1'b1;
    if (jb.reload) begin
      k_in_valid = 1'b1;
      k_in_data  = jb.kv[7:0];
    end
    @(posedge clk); #1;
    start = 1'b0;
    if (jb.reload) begin
      for (int i = 0; i < C; i++) send_k(jb.kv[8*i +: 8]);
    end
    for (int e = 0; e < jb.nx; e++) begin
      if (jb.gaps && e == 20) begin
        start    = 1'b1;
        reload_k = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        reload_k = jb.reload;
      end
      send_x(W_X'(jb.xval + jb.xinc * (e / C)), e == jb.nx - 1, jb.gaps);
    end
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy) timeout($sformatf("job%0d_busy_fall", j));
    repeat (8) @(negedge clk);
    n = res_q.size() - base;
    chk($sformatf("job%0d_count", j), n, jb.exp_n);
    for (int i = 0; i < n && i < jb.exp_n; i++) begin
      chk($sformatf("job%0d_r_data[%0d]", j, i), res_q[base+i].data, jb.exp_y + jb.exp_inc * i);
      chk($sformatf("job%0d_r_last[%0d]", j, i), res_q[base+i].last, (i == jb.exp_n - 1) ? 1 : 0);
    end
    if (n > 0) chk($sformatf("job%0d_result_latency", j), res_q[base+n-1].cyc - last_xfer_cyc, LAT);
    chk($sformatf("job%0d_busy_latency", j), busy_fall_cyc - last_xfer_cyc, LAT);
    chk($sformatf("job%0d_enable_idle", j), enable, 0);
    if (!jb.reload) chk($sformatf("job%0d_k_ready_unused", j), k_ready_cnt - kbase, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_enable"}, enable, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_k_in_ready"}, k_in_ready, 0);
    chk({tag, "_x_in_ready"}, x_in_ready, 0);
    chk({tag, "_r_valid"}, r_valid, 0);
    chk({tag, "_r_last"}, r_last, 0);
    chk({tag, "_k"}, {1'b0, k}, 0);
    chk({tag, "_x"}, {1'b0, x}, 0);
    chk({tag, "_r_data_follows_y"}, r_data, y);
  endtask

  initial begin
    int base;
    jobs[0] = '{reload: 1'b1, gaps: 1'b0, kv: 64'h0807060504030201, nx: 8,  xval: 1,    xinc: 0, exp_n: 1,  exp_y: 36,     exp_inc: 0};
    jobs[1] = '{reload: 1'b1, gaps: 1'b0, kv: 64'hFFFFFFFFFFFFFFFF, nx: 16, xval: 127,  xinc: 0, exp_n: 2,  exp_y: -1016,  exp_inc: 0};
    jobs[2] = '{reload: 1'b1, gaps: 1'b0, kv: 64'h0202020202020202, nx: 3,  xval: 5,    xinc: 0, exp_n: 1,  exp_y: 30,     exp_inc: 0};
    jobs[3] = '{reload: 1'b0, gaps: 1'b0, kv: 64'h0,                nx: 8,  xval: 3,    xinc: 0, exp_n: 1,  exp_y: 48,     exp_inc: 0};
    jobs[4] = '{reload: 1'b1, gaps: 1'b0, kv: 64'h0807060504030201, nx: 80, xval: 1,    xinc: 1, exp_n: 10, exp_y: 36,     exp_inc: 36};
    jobs[5] = '{reload: 1'b0, gaps: 1'b1, kv: 64'h0,                nx: 80, xval: 1,    xinc: 1, exp_n: 10, exp_y: 36,     exp_inc: 36};
    jobs[6] = '{reload: 1'b1, gaps: 1'b0, kv: 64'h8080808080808080, nx: 8,  xval: -128, xinc: 0, exp_n: 1,  exp_y: 131072, exp_inc: 0};
    jobs[7] = '{reload: 1'b1, gaps: 1'b0, kv: 64'h03FE02FF01007F80, nx: 8,  xval: -128, xinc: 0, exp_n: 1,  exp_y: -256,   exp_inc: 0};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int j = 0; j < 8; j++) run_job(j);

    // Abort mid-RUN: second vector just issued when reset lands.
    reload_k   = 1'b1;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < C; i++) send_k(8'(i + 1));
    for (int e = 0; e < 2 * C; e++) send_x(8'd1, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = res_q.size();
    chk_reset_outputs("abort");
    repeat (12) @(negedge clk);
    chk("abort_no_r_valid", res_q.size() - base, 0);
    chk("abort_busy_after", busy, 0);

    run_job(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

endmodule
